// File: rtl/inst_rom_resp_pkg.sv
// Shared fetch-bus definitions, state encoding and address-check helper for the
// instruction ROM responder.
package inst_rom_resp_pkg;

    localparam int          InstAddrW      = 32;
    localparam int          InstW          = 32;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        ChipDisable    = 1'b0;
    localparam logic        RstEnable      = 1'b1;
    localparam int          InstMemNum     = 1024;
    localparam int          InstMemNumLog2 = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A fetch is bad when it is not word aligned or lies beyond the array.
    function automatic logic addr_bad(input logic [31:0] a, input int aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'h0);
    endfunction

endpackage

// File: rtl/inst_rom_array.sv
// Program storage: one write port and one registered, read-first read port,
// written so synthesis can map it onto block RAM.
module inst_rom_array
    import inst_rom_resp_pkg::*;
#(
    parameter int DEPTH = InstMemNum,
    parameter int AW    = InstMemNumLog2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Non-blocking update gives old data when read and write hit the same word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: accepts fetches from the core, inserts wait
// states, and returns the instruction with a one-cycle valid pulse.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int DEPTH       = InstMemNum,
    parameter int AW          = InstMemNumLog2,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce_i,
    input  logic [31:0]   addr_i,
    output logic [31:0]   inst_o,
    output logic          inst_valid_o,
    output logic          busy_o,
    output logic          err_o,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_data_i
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] addr_q, addr_nx;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 32'h0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            addr_q <= addr_nx;
        end
    end

    // The array is read on the edge that enters RESP, using the address that
    // will be held in addr_q during that RESP cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_q;
        rd_en    = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (ce_i == ChipEnable) begin
                    addr_nx = addr_i;
                    if (WAIT_STATES == 0) begin
                        state_nx = RESP;
                        rd_en    = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (ce_i == ChipDisable) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx = RESP;
                    rd_en    = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    inst_rom_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_we_i),
        .waddr (load_addr_i),
        .wdata (load_data_i),
        .re    (rd_en),
        .raddr (addr_nx[AW+1:2]),
        .rdata (rd_data)
    );

    // Outputs depend only on registers, so an asynchronous reset clears them at once.
    assign bad          = addr_bad(addr_q, AW);
    assign busy_o       = (state == WAIT);
    assign inst_valid_o = (state == RESP);
    assign err_o        = inst_valid_o && bad;
    assign inst_o       = (inst_valid_o && !bad) ? rd_data : ZeroWord;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: a zero-wait instance driven from a vector
// table and a three-wait instance exercised with hand-written sequences.
module tb_inst_rom_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce0 = 1'b0, ce3 = 1'b0;
    logic [31:0] a0 = 32'h0, a3 = 32'h0;
    logic        lwe = 1'b0;
    logic [9:0]  laddr = 10'h0;
    logic [31:0] ldata = 32'h0;

    logic [31:0] inst0, inst3;
    logic        vld0, vld3, busy0, busy3, err0, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_rom_resp #(.DEPTH(1024), .AW(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .addr_i(a0),
        .inst_o(inst0), .inst_valid_o(vld0), .busy_o(busy0), .err_o(err0),
        .load_we_i(lwe), .load_addr_i(laddr), .load_data_i(ldata)
    );

    inst_rom_resp #(.DEPTH(1024), .AW(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .ce_i(ce3), .addr_i(a3),
        .inst_o(inst3), .inst_valid_o(vld3), .busy_o(busy3), .err_o(err3),
        .load_we_i(lwe), .load_addr_i(laddr), .load_data_i(ldata)
    );

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        we;
        logic [9:0]  la;
        logic [31:0] ld;
        logic        ev;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c0, input logic [31:0] x0, input logic c3,
                         input logic [31:0] x3, input logic we, input logic [9:0] la,
                         input logic [31:0] ld);
        @(negedge clk);
        ce0 = c0; a0 = x0; ce3 = c3; a3 = x3; lwe = we; laddr = la; ldata = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string nm, input logic ev, input logic eb,
                          input logic ee, input logic [31:0] ei);
        check({nm, " ws3 valid"}, {31'h0, vld3}, {31'h0, ev});
        check({nm, " ws3 busy"}, {31'h0, busy3}, {31'h0, eb});
        check({nm, " ws3 err"}, {31'h0, err3}, {31'h0, ee});
        check({nm, " ws3 inst"}, inst3, ei);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h3401_1100;
        prog[1] = 32'h3402_0020;
        prog[2] = 32'h3403_FF00;
        prog[3] = 32'h3404_FFFF;

        //            ce    addr          we    la     ld            ev    ei            ee
        tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0,         1'b1, 32'h3401_1100, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0004, 1'b0, 10'd0, 32'h0,         1'b1, 32'h3402_0020, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0008, 1'b0, 10'd0, 32'h0,         1'b1, 32'h3403_FF00, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_000C, 1'b0, 10'd0, 32'h0,         1'b1, 32'h3404_FFFF, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0006, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0,         1'b1};
        tbl[6]  = '{1'b1, 32'h0000_1000, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0,         1'b1};
        tbl[7]  = '{1'b1, 32'h8000_0000, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0,         1'b1};
        tbl[8]  = '{1'b1, 32'h0000_000C, 1'b0, 10'd0, 32'h0,         1'b1, 32'h3404_FFFF, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[10] = '{1'b1, 32'h0000_0008, 1'b1, 10'd2, 32'hDEAD_BEEF, 1'b1, 32'h3403_FF00, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_0008, 1'b0, 10'd0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[12] = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[13] = '{1'b1, 32'h0000_0003, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0,         1'b1};
        tbl[14] = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,         1'b0, 32'h0,         1'b0};

        // Reset state
        #12;
        check("reset ws0 valid", {31'h0, vld0}, 32'h0);
        check("reset ws0 inst", inst0, 32'h0);
        check("reset ws0 busy", {31'h0, busy0}, 32'h0);
        check("reset ws0 err", {31'h0, err0}, 32'h0);
        check3("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 10'(i), prog[i]);
        end

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ce, tbl[i].addr, 1'b0, 32'h0, tbl[i].we, tbl[i].la, tbl[i].ld);
            check($sformatf("vec%0d valid", i), {31'h0, vld0}, {31'h0, tbl[i].ev});
            check($sformatf("vec%0d inst", i), inst0, tbl[i].ei);
            check($sformatf("vec%0d err", i), {31'h0, err0}, {31'h0, tbl[i].ee});
            check($sformatf("vec%0d busy", i), {31'h0, busy0}, 32'h0);
        end

        // Three wait states; address changes during WAIT are ignored
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b0, 10'd0, 32'h0);
        check3("ws3 acc", 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 10'd0, 32'h0);
            check3($sformatf("ws3 wait%0d", i), 1'b0, 1'b1, 1'b0, 32'h0);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 10'd0, 32'h0);
        check3("ws3 resp", 1'b1, 1'b0, 1'b0, 32'h3402_0020);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        check3("ws3 idle", 1'b0, 1'b0, 1'b0, 32'h0);

        // Misaligned fetch through the wait path
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0006, 1'b0, 10'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h0000_0006, 1'b0, 10'd0, 32'h0);
        end
        check3("ws3 misalign", 1'b1, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Abort after one WAIT cycle
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0);
        check3("abort acc", 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        check3("abort drop", 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
            check3($sformatf("abort quiet%0d", i), 1'b0, 1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0);
        end
        check3("abort refetch", 1'b1, 1'b0, 1'b0, 32'h3401_1100);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Asynchronous reset: ws0 mid-RESP, ws3 mid-WAIT
        drive(1'b1, 32'h0000_0006, 1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0);
        drive(1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0);
        check("pre-rst ws0 valid", {31'h0, vld0}, 32'h1);
        check("pre-rst ws0 inst", inst0, 32'h3402_0020);
        check3("pre-rst", 1'b0, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        check("rst ws0 valid", {31'h0, vld0}, 32'h0);
        check("rst ws0 inst", inst0, 32'h0);
        check("rst ws0 err", {31'h0, err0}, 32'h0);
        check3("rst async", 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        ce0 = 1'b0; ce3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0);
        check("post-rst ws0 inst", inst0, 32'h3401_1100);
        check3("post-rst acc", 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 10'd0, 32'h0);
        end
        check3("post-rst refetch", 1'b1, 1'b0, 1'b0, 32'h3401_1100);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
